// File: rtl/bpfcap_pkg.sv
// Shared constants and types for the bpfcap capture sink.
// Holds the CSR address map, the CTRL/STATUS bit positions and the burst FSM states.
package bpfcap_pkg;

  localparam logic [2:0] CSR_CTRL    = 3'd0;
  localparam logic [2:0] CSR_STATUS  = 3'd1;
  localparam logic [2:0] CSR_LEVEL   = 3'd2;
  localparam logic [2:0] CSR_DATA    = 3'd3;
  localparam logic [2:0] CSR_THRESH  = 3'd4;
  localparam logic [2:0] CSR_WORDS   = 3'd5;
  localparam logic [2:0] CSR_DROPPED = 3'd6;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_EMPTY      = 0;
  localparam int unsigned STAT_FULL       = 1;
  localparam int unsigned STAT_IN_BURST   = 2;
  localparam int unsigned STAT_DROPPED_NZ = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } sink_state_t;

  // Beats still to come after the first beat of a burst; a burstcount of 0 counts as 1.
  function automatic logic [15:0] burst_remaining(input logic [15:0] burstcount);
    return (burstcount == 16'd0) ? 16'd0 : burstcount - 16'd1;
  endfunction

endpackage

// File: rtl/bpfcap_sink_fifo.sv
// 32-bit ring FIFO with wrap-bit pointers and registered full/empty flags.
// Push is ignored when full, pop is ignored when empty, and clear overrides both.
module bpfcap_sink_fifo #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [PW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
    end
    // Same slot index with opposite wrap bits means the ring is full.
    full_d  = (wptr_d[PW-1] != rptr_d[PW-1]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d = (wptr_d == rptr_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr_q[AW-1:0]];
  assign level = wptr_q - rptr_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/bpfcap_sink.sv
// Avalon-MM burst write sink feeding a ring FIFO, with a CSR slave for draining,
// fill-level monitoring, drop/accept counters and a threshold interrupt.
module bpfcap_sink
  import bpfcap_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] avs_d_address,
  input  logic        avs_d_write,
  input  logic [31:0] avs_d_writedata,
  input  logic [15:0] avs_d_burstcount,
  output logic        avs_d_waitrequest,
  input  logic [2:0]  avs_c_address,
  input  logic        avs_c_read,
  input  logic        avs_c_write,
  input  logic [31:0] avs_c_writedata,
  output logic [31:0] avs_c_readdata,
  output logic        avs_c_readdatavalid,
  output logic        irq
);

  sink_state_t       state_q, state_d;
  logic [15:0]       remaining_q, remaining_d;
  logic              ready_q;
  logic              enable_q, irq_en_q;
  logic [LVL_W-1:0]  thresh_q;
  logic [31:0]       words_q, dropped_q;
  logic [31:0]       readdata_q;
  logic              readdatavalid_q;
  logic              irq_q, irq_d;

  logic              accept, push, drop, pop, clear;
  logic              ctrl_wr, thresh_wr;
  logic [31:0]       fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  // The data port is stream-only, so the address is intentionally ignored.
  assign unused_bits = ^{avs_d_address, avs_c_writedata};

  // ready_q holds off the writer until the first edge after reset release.
  assign avs_d_waitrequest = !ready_q || (enable_q && fifo_full);
  assign accept = avs_d_write && !avs_d_waitrequest;
  assign push   = accept && enable_q;
  assign drop   = accept && !enable_q;

  assign ctrl_wr   = avs_c_write && (avs_c_address == CSR_CTRL);
  assign thresh_wr = avs_c_write && (avs_c_address == CSR_THRESH);
  assign clear     = ctrl_wr && avs_c_writedata[CTRL_CLEAR];
  assign pop       = avs_c_read && (avs_c_address == CSR_DATA);

  bpfcap_sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (avs_d_writedata),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          remaining_d = burst_remaining(avs_d_burstcount);
          if (remaining_d != 16'd0) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (accept) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (avs_c_address)
      CSR_CTRL: begin
        rd_mux[CTRL_ENABLE] = enable_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      CSR_STATUS: begin
        rd_mux[STAT_EMPTY]      = fifo_empty;
        rd_mux[STAT_FULL]       = fifo_full;
        rd_mux[STAT_IN_BURST]   = (state_q == S_BURST);
        rd_mux[STAT_DROPPED_NZ] = (dropped_q != 32'd0);
      end
      CSR_LEVEL:   rd_mux = 32'(fifo_level);
      CSR_DATA:    rd_mux = fifo_empty ? 32'd0 : fifo_rdata;
      CSR_THRESH:  rd_mux = 32'(thresh_q);
      CSR_WORDS:   rd_mux = words_q;
      CSR_DROPPED: rd_mux = dropped_q;
      default:     rd_mux = '0;
    endcase
  end

  assign irq_d = irq_en_q && (thresh_q != '0) && (fifo_level >= thresh_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      ready_q         <= 1'b0;
      enable_q        <= 1'b0;
      irq_en_q        <= 1'b0;
      thresh_q        <= '0;
      words_q         <= '0;
      dropped_q       <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      ready_q         <= 1'b1;
      if (ctrl_wr) begin
        enable_q <= avs_c_writedata[CTRL_ENABLE];
        irq_en_q <= avs_c_writedata[CTRL_IRQ_EN];
      end
      if (thresh_wr) thresh_q <= avs_c_writedata[LVL_W-1:0];
      if (push) words_q <= words_q + 32'd1;
      if (drop) dropped_q <= dropped_q + 32'd1;
      readdata_q      <= avs_c_read ? rd_mux : 32'd0;
      readdatavalid_q <= avs_c_read;
      irq_q           <= irq_d;
    end
  end

  assign avs_c_readdata      = readdata_q;
  assign avs_c_readdatavalid = readdatavalid_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_bpfcap_sink.sv
// Directed self-checking bench for bpfcap_sink with an 8-word FIFO.
module tb_bpfcap_sink;
  import bpfcap_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = 4;

  logic        clk;
  logic        reset;
  logic [31:0] avs_d_address;
  logic        avs_d_write;
  logic [31:0] avs_d_writedata;
  logic [15:0] avs_d_burstcount;
  logic        avs_d_waitrequest;
  logic [2:0]  avs_c_address;
  logic        avs_c_read;
  logic        avs_c_write;
  logic [31:0] avs_c_writedata;
  logic [31:0] avs_c_readdata;
  logic        avs_c_readdatavalid;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  bpfcap_sink #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .avs_d_address       (avs_d_address),
    .avs_d_write         (avs_d_write),
    .avs_d_writedata     (avs_d_writedata),
    .avs_d_burstcount    (avs_d_burstcount),
    .avs_d_waitrequest   (avs_d_waitrequest),
    .avs_c_address       (avs_c_address),
    .avs_c_read          (avs_c_read),
    .avs_c_write         (avs_c_write),
    .avs_c_writedata     (avs_c_writedata),
    .avs_c_readdata      (avs_c_readdata),
    .avs_c_readdatavalid (avs_c_readdatavalid),
    .irq                 (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_beat(input logic [31:0] data, input logic [15:0] bc);
    int n;
    avs_d_write      = 1'b1;
    avs_d_writedata  = data;
    avs_d_burstcount = bc;
    n = 0;
    while (avs_d_waitrequest && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("beat_accept_timeout", {31'b0, avs_d_waitrequest}, 32'd0);
    tick();
    avs_d_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    avs_c_read    = 1'b1;
    avs_c_address = a;
    tick();
    avs_c_read = 1'b0;
    chk("readdatavalid", {31'b0, avs_c_readdatavalid}, 32'd1);
    d = avs_c_readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] data);
    avs_c_write     = 1'b1;
    avs_c_address   = a;
    avs_c_writedata = data;
    tick();
    avs_c_write = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    avs_d_address    = 32'h0;
    avs_d_write      = 1'b0;
    avs_d_writedata  = 32'h0;
    avs_d_burstcount = 16'd0;
    avs_c_address    = 3'd0;
    avs_c_read       = 1'b0;
    avs_c_write      = 1'b0;
    avs_c_writedata  = 32'h0;

    // Reset values
    tick();
    tick();
    chk("rst_waitrequest", {31'b0, avs_d_waitrequest}, 32'd1);
    chk("rst_rdvalid", {31'b0, avs_c_readdatavalid}, 32'd0);
    chk("rst_readdata", avs_c_readdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    chk("rel_waitrequest_before_edge", {31'b0, avs_d_waitrequest}, 32'd1);
    tick();
    chk("rel_waitrequest_after_edge", {31'b0, avs_d_waitrequest}, 32'd0);
    rd_chk("rst_ctrl", CSR_CTRL, 32'd0);
    rd_chk("rst_status", CSR_STATUS, 32'd1);
    rd_chk("rst_level", CSR_LEVEL, 32'd0);
    rd_chk("rst_thresh", CSR_THRESH, 32'd0);

    // 8-beat burst of 10..17 fills the FIFO exactly
    csr_write(CSR_CTRL, 32'd1);
    for (int i = 0; i < 3; i++) d_beat(32'd10 + 32'(i), 16'd8);
    rd_chk("mid_burst_status", CSR_STATUS, 32'd4);
    for (int i = 3; i < 8; i++) d_beat(32'd10 + 32'(i), 16'd8);
    chk("full_waitrequest", {31'b0, avs_d_waitrequest}, 32'd1);
    rd_chk("burst8_status", CSR_STATUS, 32'd2);
    rd_chk("burst8_level", CSR_LEVEL, 32'd8);
    rd_chk("burst8_words", CSR_WORDS, 32'd8);
    for (int i = 0; i < 8; i++) rd_chk("burst8_data", CSR_DATA, 32'd10 + 32'(i));
    rd_chk("burst8_drained_status", CSR_STATUS, 32'd1);

    // Backpressure: 10-beat burst into 8 slots, one pop lets exactly one more beat in
    for (int i = 0; i < 8; i++) d_beat(32'd100 + 32'(i), 16'd10);
    avs_d_write     = 1'b1;
    avs_d_writedata = 32'd108;
    tick();
    tick();
    chk("bp_stalled", {31'b0, avs_d_waitrequest}, 32'd1);
    rd_chk("bp_level_full", CSR_LEVEL, 32'd8);
    rd_chk("bp_pop_first", CSR_DATA, 32'd100);
    chk("bp_unblocked", {31'b0, avs_d_waitrequest}, 32'd0);
    tick();
    avs_d_writedata = 32'd109;
    chk("bp_stalled_again", {31'b0, avs_d_waitrequest}, 32'd1);
    tick();
    chk("bp_still_stalled", {31'b0, avs_d_waitrequest}, 32'd1);
    avs_d_write = 1'b0;
    rd_chk("bp_level_after_one", CSR_LEVEL, 32'd8);
    for (int i = 1; i < 9; i++) rd_chk("bp_data", CSR_DATA, 32'd100 + 32'(i));
    rd_chk("bp_in_burst_before_last", CSR_STATUS, 32'd5);
    d_beat(32'd109, 16'd10);
    rd_chk("bp_last_data", CSR_DATA, 32'd109);
    rd_chk("bp_status_idle", CSR_STATUS, 32'd1);
    rd_chk("bp_words", CSR_WORDS, 32'd18);

    // Disabled: beats accepted and discarded
    csr_write(CSR_CTRL, 32'd0);
    for (int i = 0; i < 5; i++) d_beat(32'd200 + 32'(i), 16'd1);
    rd_chk("drop_count", CSR_DROPPED, 32'd5);
    rd_chk("drop_level", CSR_LEVEL, 32'd0);
    rd_chk("drop_words", CSR_WORDS, 32'd18);
    rd_chk("drop_status", CSR_STATUS, 32'd9);

    // Threshold interrupt at 3 words
    csr_write(CSR_THRESH, 32'd3);
    csr_write(CSR_CTRL, 32'd5);
    d_beat(32'd1, 16'd1);
    d_beat(32'd2, 16'd1);
    d_beat(32'd3, 16'd1);
    chk("irq_not_yet", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_rise", {31'b0, irq}, 32'd1);
    rd_chk("irq_pop", CSR_DATA, 32'd1);
    chk("irq_hold_at_pop", {31'b0, irq}, 32'd1);
    tick();
    chk("irq_fall", {31'b0, irq}, 32'd0);

    // Clear mid-burst: the rest of the burst lands in the emptied FIFO
    csr_write(CSR_CTRL, 32'd3);
    rd_chk("clear_level", CSR_LEVEL, 32'd0);
    rd_chk("clear_reads_zero", CSR_CTRL, 32'd1);
    d_beat(32'd40, 16'd4);
    d_beat(32'd41, 16'd4);
    csr_write(CSR_CTRL, 32'd3);
    rd_chk("midclr_level", CSR_LEVEL, 32'd0);
    rd_chk("midclr_status", CSR_STATUS, 32'd13);
    d_beat(32'd42, 16'd4);
    d_beat(32'd43, 16'd4);
    rd_chk("midclr_level_after", CSR_LEVEL, 32'd2);
    rd_chk("midclr_status_after", CSR_STATUS, 32'd8);
    rd_chk("midclr_data0", CSR_DATA, 32'd42);
    rd_chk("midclr_data1", CSR_DATA, 32'd43);

    // Empty DATA read, then burstcount 0 as a single beat
    rd_chk("empty_data", CSR_DATA, 32'd0);
    rd_chk("empty_level", CSR_LEVEL, 32'd0);
    d_beat(32'd55, 16'd0);
    rd_chk("bc0_status", CSR_STATUS, 32'd8);
    rd_chk("bc0_data", CSR_DATA, 32'd55);

    // Simultaneous push and pop keeps LEVEL and order
    d_beat(32'd77, 16'd1);
    avs_d_write      = 1'b1;
    avs_d_writedata  = 32'd78;
    avs_d_burstcount = 16'd1;
    avs_c_read       = 1'b1;
    avs_c_address    = CSR_DATA;
    tick();
    avs_d_write = 1'b0;
    avs_c_read  = 1'b0;
    chk("pushpop_data", avs_c_readdata, 32'd77);
    rd_chk("pushpop_level", CSR_LEVEL, 32'd1);
    rd_chk("pushpop_next", CSR_DATA, 32'd78);

    // Simultaneous clear and push: clear wins
    avs_d_write     = 1'b1;
    avs_d_writedata = 32'd90;
    avs_c_write     = 1'b1;
    avs_c_address   = CSR_CTRL;
    avs_c_writedata = 32'd3;
    tick();
    avs_d_write = 1'b0;
    avs_c_write = 1'b0;
    rd_chk("clrpush_level", CSR_LEVEL, 32'd0);
    rd_chk("clrpush_words", CSR_WORDS, 32'd29);

    // Read-only and unmapped addresses
    csr_write(CSR_LEVEL, 32'd5);
    csr_write(3'd7, 32'hFFFF_FFFF);
    rd_chk("ro_level", CSR_LEVEL, 32'd0);
    rd_chk("addr7", 3'd7, 32'd0);
    rd_chk("thresh_kept", CSR_THRESH, 32'd3);

    // Reset mid-burst returns the FSM to IDLE
    d_beat(32'd60, 16'd4);
    rd_chk("prereset_status", CSR_STATUS, 32'd12);
    reset = 1'b1;
    #1;
    chk("reset_waitrequest", {31'b0, avs_d_waitrequest}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    rd_chk("postreset_status", CSR_STATUS, 32'd1);
    rd_chk("postreset_words", CSR_WORDS, 32'd0);
    rd_chk("postreset_ctrl", CSR_CTRL, 32'd0);
    d_beat(32'd61, 16'd1);
    rd_chk("postreset_drop_status", CSR_STATUS, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bpfcap_sink.md
# bpfcap_sink

Capture sink directly downstream of `bpfcap_top`. It acts as the Avalon-MM burst write slave that `bpfcap_top`'s `avs_m1` write master targets, and buffers accepted 32-bit words in an on-chip ring FIFO. A separate CSR slave lets the host drain words, monitor fill level and take a threshold interrupt. Backpressure is applied with `waitrequest` whenever the FIFO is full; data is never silently lost while enabled.

## Interface

Parameters:
- `DEPTH`, 256: FIFO depth in 32-bit words; must be a power of 2, ≥ 4.
- `LVL_W`, `$clog2(DEPTH)+1`: level and threshold width.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `avs_d_address` in 32: ignored (stream semantics).
- `avs_d_write` in 1: write beat request.
- `avs_d_writedata` in 32: beat data.
- `avs_d_burstcount` in 16: beats in the burst; sampled on the first beat only; 0 is treated as 1.
- `avs_d_waitrequest` out 1: stall; the beat is accepted when `write && !waitrequest`.
- `avs_c_address` in 3: CSR word address.
- `avs_c_read` in 1, `avs_c_write` in 1, `avs_c_writedata` in 32: CSR access.
- `avs_c_readdata` out 32, `avs_c_readdatavalid` out 1: fixed read latency of 1.
- `irq` out 1: level interrupt, registered.

## Operation

CSR map:
- 0 CTRL (RW):
  - bit0 `enable`.
  - bit1 `clear`: write-1 pulse, reads 0.
  - bit2 `irq_en`.
- 1 STATUS (RO):
  - bit0 `empty`, bit1 `full`, bit2 `in_burst`.
  - bit3 `dropped_nz`.
- 2 LEVEL (RO): words stored, 0..DEPTH.
- 3 DATA (RO): a read pops the FIFO head. A read when empty returns 0 and leaves the pointers unchanged.
- 4 THRESH (RW, LVL_W bits).
- 5 WORDS (RO): 32-bit count of accepted beats; wraps at 2^32.
- 6 DROPPED (RO): 32-bit count of beats discarded while `enable`=0; wraps.
- 7: reads 0; writes are ignored.
- Writes to RO addresses are ignored.

Data path:
- `enable`=1: each accepted beat is pushed into the FIFO.
- `enable`=0: `waitrequest`=0, beats are accepted and discarded, and DROPPED increments by 1 per beat.

Burst FSM:
- IDLE: an accepted beat loads `remaining = max(burstcount,1)-1`. Stay in IDLE if `remaining`=0, else go to BURST.
- BURST: each accepted beat decrements `remaining`. Return to IDLE when a beat is accepted with `remaining`=1.
- `in_burst` = (state==BURST).

`clear`:
- Resets the FIFO pointers and LEVEL to 0 in the cycle after the write.
- Does not touch the FSM, counters or THRESH. An in-progress burst continues into the emptied FIFO.

`irq` = registered(`irq_en && THRESH!=0 && LEVEL>=THRESH`).

## Timing

Reset values:
- `avs_d_waitrequest`=1 while `reset` is high and 0 from the first clock edge after release.
- `avs_c_readdata`=0, `avs_c_readdatavalid`=0, `irq`=0.
- CTRL=0, THRESH=0, counters=0, FSM=IDLE, FIFO empty.

Data port:
- `avs_d_waitrequest` = `enable && full`, with `full` the registered flag. A pop in the same cycle does not unblock that cycle; the push is accepted the following cycle.
- An accepted beat is visible in LEVEL and WORDS one cycle after acceptance.

CSR port:
- A read issued in cycle N returns `readdata`/`readdatavalid`=1 in cycle N+1.
- A DATA pop takes effect at N. LEVEL read at N+1 reflects the pop.
- Simultaneous push and pop when not full: LEVEL is unchanged and the data ordering is preserved.
- Simultaneous `clear` and push: `clear` wins; LEVEL becomes 0.
- A CSR write takes effect the cycle after it is issued.

Wrap and reset:
- Pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH. `full` is true when the MSBs differ and the remaining bits are equal.
- `reset` asserted mid-burst returns the FSM to IDLE immediately. The remainder of that burst is treated as new bursts after release.

## Structure

- `bpfcap_pkg`:
  - CSR address constants (`CSR_CTRL` .. `CSR_DROPPED`).
  - CTRL bit indices.
  - FSM enum `sink_state_t {S_IDLE, S_BURST}`.
- Sub-module `bpfcap_sink_fifo`:
  - Parameters `DEPTH`, 32-bit width.
  - Ports `push`/`pop`/`clear`/`wdata`/`rdata`/`level`/`full`/`empty`.
  - Registered flags; asynchronous active-high `reset`.
- The top level holds the FSM, CSRs, counters and irq.

## Test plan

- Enable, single 8-beat burst of 10..17 with `burstcount`=8 → LEVEL=8, WORDS=8, `in_burst` low after the 8th beat, 8 DATA reads return 10..17 in order, then `empty`=1.
- DEPTH=4, 6-beat burst with no pops → `waitrequest` high after 4 beats. Pop one word → exactly one more beat is accepted, no data lost, final sequence correct.
- `enable`=0, 5 beats → all accepted, DROPPED=5, LEVEL=0, WORDS=0.
- THRESH=3, `irq_en`=1 → `irq` rises the cycle after LEVEL reaches 3 and falls the cycle after a pop to LEVEL=2.
- `clear` mid-burst (2 of 4 beats done) → LEVEL=0, remaining 2 beats stored, LEVEL=2, FSM back in IDLE.
- DATA read when empty → `readdata`=0, `readdatavalid`=1 at N+1. Burst with `burstcount`=0 → treated as a single beat, FSM stays IDLE.
